// File: rtl/eeprom_ctrl.sv
// Bus-side controller for a 2K x 8 parallel EEPROM: accepts single-byte read/write
// requests and sequences ce_n/oe_n/we_n with programmable setup, strobe, hold and recovery.
module eeprom_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int WRITE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_doe,
  input  logic [DATA_W-1:0] mem_din
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WREC} state_t;

  // Counter reload values: a state lasting N cycles starts its count at N-1.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] WREC_LD  = (WRITE_CYC == 0) ? 8'd0 : 8'(WRITE_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       we_q;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      we_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_addr  <= '0;
      mem_dout  <= '0;
      mem_doe   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= SETUP;
            cnt      <= SETUP_LD;
            we_q     <= req_we;
            busy     <= 1'b1;
            mem_ce_n <= 1'b0;
            mem_addr <= req_addr;
            if (req_we) begin
              mem_dout <= req_wdata;
              mem_doe  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state <= PULSE;
            cnt   <= PULSE_LD;
            if (we_q) mem_we_n <= 1'b0;
            else      mem_oe_n <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PULSE: begin
          // Read data is taken on the same edge that releases oe_n.
          if (cnt == 8'd0) begin
            state    <= HOLD;
            cnt      <= HOLD_LD;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            if (!we_q) rsp_rdata <= mem_din;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            mem_ce_n <= 1'b1;
            mem_doe  <= 1'b0;
            if (we_q && (WRITE_CYC != 0)) begin
              state <= WREC;
              cnt   <= WREC_LD;
            end else begin
              state     <= IDLE;
              rsp_valid <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WREC: begin
          if (cnt == 8'd0) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eeprom_ctrl.md
# eeprom_ctrl

Bus-side controller for the 2K x 8 parallel EEPROM (active-low ce_n/oe_n/we_n, 11-bit address, shared 8-bit data bus). It accepts single-byte read/write requests from the CPU core over a valid/ready handshake and sequences the EEPROM control pins with programmable setup, strobe, hold and write-recovery times. The shared data bus is split into dout/doe/din so the top level can map it onto bidirectional pads.

## Interface
- ADDR_W, 11, address width.
- DATA_W, 8, data width.
- SETUP_CYC, 1, cycles ce_n low with address/data stable before the strobe (1..255).
- PULSE_CYC, 2, cycles oe_n or we_n held low (1..255).
- HOLD_CYC, 1, cycles ce_n low after the strobe rises (1..255).
- WRITE_CYC, 8, write-recovery cycles with chip deselected after a write (0..255; 0 skips recovery).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads, holds its value until the next read completes.
- busy  out  1  high in every non-IDLE state.
- mem_ce_n  out  1  EEPROM chip enable.
- mem_oe_n  out  1  EEPROM output enable.
- mem_we_n  out  1  EEPROM write enable.
- mem_addr  out  ADDR_W  EEPROM address.
- mem_dout  out  DATA_W  data driven to the EEPROM.
- mem_doe  out  1  drive enable for mem_dout.
- mem_din  in  DATA_W  data from the EEPROM.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WREC. A single 8-bit down-counter times every state.
- Acceptance: req_valid && req_ready at a rising edge. req_addr, req_we and req_wdata are captured into registers at that edge. Later changes to the req_* inputs have no effect. When req_ready is low, req_valid is ignored.
- IDLE: mem_ce_n=1, mem_oe_n=1, mem_we_n=1, mem_doe=0. mem_addr and mem_dout keep their last values.
- SETUP (SETUP_CYC cycles): mem_ce_n=0 and mem_addr driven.
  - Write: mem_doe=1 and mem_dout=wdata.
  - Read: mem_doe=0.
- PULSE (PULSE_CYC cycles):
  - Read: mem_oe_n=0.
  - Write: mem_we_n=0, with doe/dout still driven.
- HOLD (HOLD_CYC cycles): strobes high, mem_ce_n=0, address held.
  - Write: mem_doe stays 1 through HOLD.
- WREC (WRITE_CYC cycles, writes only): mem_ce_n=1 and mem_doe=0. Skipped when WRITE_CYC=0.
- Completion: on leaving HOLD (reads, or writes with WRITE_CYC=0) or WREC, go to IDLE and pulse rsp_valid for one cycle.
- Read capture: mem_din is sampled into rsp_rdata at the edge that ends the last PULSE cycle. mem_oe_n rises at that same edge.
- Invariants:
  - mem_doe=1 and mem_oe_n=0 never occur together.
  - mem_oe_n and mem_we_n are never low together.
  - Strobes are low only while mem_ce_n=0.
- All mem_* outputs, rsp_valid, rsp_rdata and busy are registered. req_ready is decoded from state (IDLE).
- Reset (asynchronous, any state, including mid-write):
  - Immediate return to IDLE.
  - mem_ce_n=1, mem_oe_n=1, mem_we_n=1, mem_doe=0, mem_addr=0, mem_dout=0.
  - rsp_valid=0, rsp_rdata=0, busy=0, req_ready=1 after release.
  - No rsp_valid is produced for the aborted transaction. The aborted write location's contents are undefined.

## Timing
- Request accepted at edge E0; the state enters SETUP at E0.
- Read: mem_oe_n falls at E0+SETUP_CYC and rises at E0+SETUP_CYC+PULSE_CYC. rsp_valid is high in the cycle starting at E0+SETUP_CYC+PULSE_CYC+HOLD_CYC. Defaults: oe_n low E1..E3, rsp_valid at E4.
- Write: mem_we_n is low from E0+SETUP_CYC for PULSE_CYC cycles. rsp_valid is high at E0+SETUP_CYC+PULSE_CYC+HOLD_CYC+WRITE_CYC. Defaults: rsp_valid at E12.
- req_ready rises in the same cycle as rsp_valid, so a back-to-back request can be accepted then. This guarantees mem_ce_n is high for at least one cycle between transactions.
- Throughput: one transaction per SETUP_CYC+PULSE_CYC+HOLD_CYC(+WRITE_CYC)+1 cycles.

## Test plan
- Reset mid-PULSE of a write → all strobes high, mem_doe=0, mem_addr=0 immediately (asynchronous), no rsp_valid, req_ready=1 after release.
- Write 0xA5 to 0x000, then read 0x000 against an EEPROM model (defaults) → we_n low exactly 2 cycles, rsp_valid at E12; read rsp_valid at E4 with rsp_rdata=0xA5.
- Write 0x3C to 0x001 then read 0x001; also read 0x7FF after writing 0x5A there → rsp_rdata=0x3C and 0x5A, respectively.
- req_valid held high continuously with alternating reads and writes → every transaction is accepted in its rsp_valid cycle, and mem_ce_n is high for 1 cycle between reads and for WRITE_CYC+1 cycles after writes.
- Change req_addr and req_wdata while busy, and pulse req_valid while busy → no effect on the pins and no extra transaction.
- Instantiate with SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=1, WRITE_CYC=0 → write rsp_valid at E3. A checker asserts the doe/oe_n and strobe invariants on every cycle throughout.
